// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using the shift-and-add-3
// (double dabble) method. One bit is processed per clock. Optional
// leading-zero blanking replaces leading zero digits with 4'hF.
//
// Ports
//   clock     in   1          rising-edge clock
//   reset     in   1          asynchronous active-high reset
//   start     in   1          conversion request (ignored while busy)
//   bin       in   WIDTH      unsigned value, sampled with start
//   blank_lz  in   1          leading-zero blanking enable, sampled with start
//   busy      out  1          conversion in progress
//   done      out  1          one-cycle pulse: new result on bcd
//   bcd       out  4*DIGITS   result, digit k at [4k+3:4k]
//
// state  | meaning
// IDLE   | waiting for start; bcd holds the last result
// SHIFT  | WIDTH add-3/shift steps on {scratch, binary}
// FINISH | publish blanked scratch to bcd, pulse done

module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_bin;
    logic [4*DIGITS-1:0]  r_scratch;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [CW-1:0]        r_cnt;
    logic                 r_blank;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_last;
    logic [4*DIGITS-1:0]  w_adj;
    logic [4*DIGITS-1:0]  w_blanked;
    logic                 w_lead;

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

    // Counter holds the number of completed shifts; the step that sees
    // WIDTH-1 is the final one.
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = FINISH;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pre-shift correction: any digit >= 5 would become >= 10 after doubling.
    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // Walk from the top digit down; blank zeros until the first non-zero.
    // Digit 0 is always shown.
    always_comb begin
        w_blanked = r_scratch;
        w_lead    = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (r_scratch[4*k +: 4] != 4'd0) begin
                w_lead = 1'b0;
            end else if (w_lead && r_blank) begin
                w_blanked[4*k +: 4] = 4'hF;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_blank   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin     <= bin;
                        r_blank   <= blank_lz;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    {r_scratch, r_bin} <= {w_adj[4*DIGITS-2:0], r_bin, 1'b0};
                    r_cnt              <= r_cnt + CW'(1);
                end
                FINISH: begin
                    r_bcd  <= w_blanked;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] bin      = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd)
    );

    typedef struct {
        logic [15:0] b;
        logic        bl;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int v, input logic bl);
        logic [19:0] r;
        int          t    = v;
        bit          lead = 1'b1;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        for (int k = 4; k >= 1; k--) begin
            if (r[4*k +: 4] != 4'd0) lead = 1'b0;
            else if (lead && bl) r[4*k +: 4] = 4'hF;
        end
        return r;
    endfunction

    // Call 1 time unit after a rising edge with the DUT idle (or in its done
    // cycle). Returns at 1 time unit after the edge that raised done.
    task automatic run_conv(input logic [15:0] b, input logic bl,
                            output logic [19:0] res, output int lat,
                            output int busy_cnt, output logic hold_ok,
                            output logic busy_at_done);
        logic [19:0] prev;
        prev         = bcd;
        start        = 1'b1;
        bin          = b;
        blank_lz     = bl;
        @(posedge clock); #1;
        start        = 1'b0;
        bin          = 16'($urandom);
        blank_lz     = ~bl;
        lat          = 0;
        busy_cnt     = 0;
        hold_ok      = 1'b1;
        busy_at_done = 1'b1;
        res          = 'x;
        for (int n = 1; n <= 40; n++) begin
            if (busy) busy_cnt++;
            if (bcd !== prev) hold_ok = 1'b0;
            @(posedge clock); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        res          = bcd;
        busy_at_done = busy;
    endtask

    initial begin
        logic [19:0] res;
        logic [19:0] prev;
        logic        hold_ok;
        logic        bad_busy;
        logic        hold_bad;
        int          lat;
        int          lat2;
        int          bcnt;
        int          dones;
        logic [15:0] v;
        logic        bl;

        vecs.push_back('{16'd0,     1'b0, 20'h00000});
        vecs.push_back('{16'd65535, 1'b0, 20'h65535});
        vecs.push_back('{16'd42,    1'b1, 20'hFFF42});
        vecs.push_back('{16'd0,     1'b1, 20'hFFFF0});
        vecs.push_back('{16'd9,     1'b1, 20'hFFFF9});
        vecs.push_back('{16'd10,    1'b1, 20'hFFF10});
        vecs.push_back('{16'd1000,  1'b1, 20'hF1000});
        vecs.push_back('{16'd10000, 1'b1, 20'h10000});
        vecs.push_back('{16'd12,    1'b0, 20'h00012});
        vecs.push_back('{16'd60000, 1'b1, 20'h60000});
        vecs.push_back('{16'd101,   1'b1, 20'hFF101});
        vecs.push_back('{16'd9999,  1'b0, 20'h09999});

        repeat (3) @(posedge clock);
        #1;
        chk("rst_bcd",  32'(bcd),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            run_conv(vecs[i].b, vecs[i].bl, res, lat, bcnt, hold_ok, bad_busy);
            chk($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_lat", i), lat, 17);
            chk($sformatf("vec%0d_busy_done", i), 32'(bad_busy), 32'h0);
            chk($sformatf("vec%0d_hold", i), 32'(hold_ok), 32'h1);
            if (i == 0) chk("vec0_busy_cycles", bcnt, 17);
        end
        @(posedge clock); #1;
        chk("done_one_cycle", 32'(done), 32'h0);

        // Start while busy must be ignored; bcd holds until done.
        prev     = bcd;
        start    = 1'b1;
        bin      = 16'd1234;
        blank_lz = 1'b0;
        @(posedge clock); #1;
        dones    = 0;
        lat      = 0;
        hold_bad = 1'b0;
        res      = '0;
        for (int n = 1; n <= 45; n++) begin
            start = (n == 5);
            bin   = (n == 5) ? 16'd9999 : 16'd1234;
            @(posedge clock); #1;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    res = bcd;
                    lat = n;
                end
            end else if (dones == 0 && bcd !== prev) begin
                hold_bad = 1'b1;
            end
        end
        start = 1'b0;
        chk("busy_start_dones", dones, 1);
        chk("busy_start_bcd", 32'(res), 32'h01234);
        chk("busy_start_lat", lat, 17);
        chk("busy_start_hold", 32'(hold_bad), 32'h0);

        // Back-to-back: start in the done cycle.
        run_conv(16'd100, 1'b0, res, lat, bcnt, hold_ok, bad_busy);
        chk("b2b_first", 32'(res), 32'h00100);
        run_conv(16'd7, 1'b0, res, lat2, bcnt, hold_ok, bad_busy);
        chk("b2b_second", 32'(res), 32'h00007);
        chk("b2b_gap", lat2 + 1, 18);

        // Reset mid-conversion.
        start    = 1'b1;
        bin      = 16'd500;
        blank_lz = 1'b0;
        @(posedge clock); #1;
        start    = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_bcd",  32'(bcd),  32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        chk("midrst_no_done", dones, 0);
        run_conv(16'd500, 1'b0, res, lat, bcnt, hold_ok, bad_busy);
        chk("midrst_restart", 32'(res), 32'h00500);
        chk("midrst_restart_lat", lat, 17);

        // Random values against a decimal reference model.
        for (int i = 0; i < 1000; i++) begin
            v  = 16'($urandom_range(0, 65535));
            bl = 1'($urandom_range(0, 1));
            run_conv(v, bl, res, lat, bcnt, hold_ok, bad_busy);
            chk($sformatf("rand%0d_bcd(%0d,%0d)", i, v, bl), 32'(res), 32'(ref_bcd(int'(v), bl)));
            chk($sformatf("rand%0d_lat", i), lat, 17);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, binary input width in bits.
REQ-002 SHALL provide parameter DIGITS, default 5, number of BCD output digits; legal only when 10^DIGITS > 2^WIDTH-1.
REQ-003 SHALL provide port: clock  in  1  rising-edge clock; the block's only clock.
REQ-004 SHALL provide port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL provide port: start  in  1  conversion request, sampled on the clock edge.
REQ-006 SHALL provide port: bin  in  WIDTH  unsigned binary value to convert, sampled with start.
REQ-007 SHALL provide port: blank_lz  in  1  leading-zero blanking enable, sampled with start.
REQ-008 SHALL provide port: busy  out  1  high while a conversion is in progress.
REQ-009 SHALL provide port: done  out  1  one-cycle pulse marking a new result on bcd.
REQ-010 SHALL provide port: bcd  out  4*DIGITS  result; digit k (least significant k=0) occupies bits [4k+3:4k].

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, FINISH; all outputs registered.
REQ-012 IDLE: on an edge with start=1, SHALL capture bin into the shift register and blank_lz into a flag, clear the BCD scratch and the bit counter, and go to SHIFT.
REQ-013 SHIFT: each edge SHALL first add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one bit (binary MSB enters digit 0 LSB) and increment the counter.
REQ-014 SHIFT SHALL last exactly WIDTH edges, then go to FINISH.
REQ-015 FINISH: one edge SHALL write the scratch to bcd with blanking applied, pulse done=1 for one cycle, and return to IDLE.
REQ-016 Blanking: when the captured flag=1, every digit above digit 0 that is 0 and has only zero digits above it SHALL be output as 4'hF (blank code); digit 0 SHALL never be blanked.
REQ-017 Latency: done SHALL be high in the cycle following edge E0+WIDTH+1, where E0 is the edge that sampled start (17 cycles for WIDTH=16).
REQ-018 busy SHALL be 1 in SHIFT and FINISH and 0 in IDLE; busy=0 and done=1 hold simultaneously in the done cycle.
REQ-019 start while busy=1 SHALL be ignored with no queuing; bin and blank_lz changes during a conversion SHALL have no effect.
REQ-020 start=1 in the done cycle SHALL be accepted, allowing back-to-back conversions every WIDTH+2 cycles.
REQ-021 bcd SHALL hold the previous result unchanged until the FINISH edge; intermediate scratch values SHALL never appear on bcd.
REQ-022 Scratch digits SHALL never exceed 9 after an add-3/shift step; no carry SHALL leave the top digit for legal parameters.

Reset
REQ-023 Asserting reset SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, bcd=0, with counter, scratch and flag cleared.
REQ-024 Reset asserted mid-conversion SHALL abort it; no done pulse SHALL follow, and the first post-reset edge with start=1 SHALL begin a fresh conversion.

Verification
REQ-025 bin=16'd0, blank_lz=0, start 1 cycle -> done after 17 cycles, bcd=20'h00000, busy high for exactly 17 cycles.
REQ-026 bin=16'd65535, blank_lz=0 -> bcd=20'h65535; then bin=16'd42, blank_lz=1 -> bcd=20'hFFF42; then bin=0, blank_lz=1 -> bcd=20'hFFFF0.
REQ-027 bin=16'd1234 started; at cycle 5 apply start=1 with bin=16'd9999 -> only one done pulse, bcd=20'h01234; bcd unchanged before done.
REQ-028 bin=16'd100 then start=1 in the done cycle with bin=16'd7 -> second done exactly 18 cycles after the first, bcd=20'h00007.
REQ-029 Reset pulse at cycle 8 of a conversion of 16'd500 -> outputs zero immediately, no done pulse; next start with bin=16'd500 -> bcd=20'h00500.
REQ-030 Random bins (>=1000 values, both blank_lz settings) -> bcd SHALL match a reference decimal model on every done pulse.
